tlb_mport: RTL and testbench
============================

Name: tlb_mport

Overview:
- Parametrised successor to the 16-entry dual-search TLB: fully associative, TLBNUM entries, NPORT independent search ports.
- Search results are registered (1-cycle latency); the block owns the CP0 Random counter; TLBP/TLBR are registered ops; multi-match is detected.
- Sits between the I/D TLB buffers and CP0; the TLBWI/TLBWR/TLBP/TLBR controls come from the MEM stage.

Parameters:
- TLBNUM, 16: number of entries; power of two, 4..64.
- NPORT, 2: number of search ports, 1..4.
- IDXW, $clog2(TLBNUM): index width (derived, not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- s_req  in  NPORT  per-port lookup strobe.
- s_vpn2  in  NPORT*19  per-port VA[31:13]; port p at [p*19+:19].
- s_odd  in  NPORT  per-port VA[12]; selects the odd page.
- asid  in  8  current EntryHi.ASID, shared by all ports and by TLBP.
- s_found  out  NPORT  registered hit.
- s_index  out  NPORT*IDXW  registered hit index.
- s_pfn  out  NPORT*20  registered PFN of the selected page.
- s_c  out  NPORT*3  registered cache attribute.
- s_d  out  NPORT  registered dirty.
- s_v  out  NPORT  registered valid.
- s_multi  out  NPORT  registered: more than one entry matched.
- tlbw  in  1  write strobe.
- tlbwr  in  1  1 selects a random write (index = random), 0 selects an indexed write (index = w_index).
- w_index  in  IDXW  CP0 Index.
- w_vpn2  in  19  EntryHi field.
- w_asid  in  8  EntryHi field.
- w_g  in  1  G0&G1, pre-ANDed by CP0.
- w_pfn0  in  20  EntryLo0 field.
- w_c0  in  3  EntryLo0 field.
- w_d0  in  1  EntryLo0 field.
- w_v0  in  1  EntryLo0 field.
- w_pfn1  in  20  EntryLo1 field.
- w_c1  in  3  EntryLo1 field.
- w_d1  in  1  EntryLo1 field.
- w_v1  in  1  EntryLo1 field.
- tlbp  in  1  probe strobe, using w_vpn2 and asid.
- p_done  out  1  probe result valid, 1-cycle pulse.
- p_found  out  1  probe hit.
- p_index  out  IDXW  probe hit index.
- tlbr  in  1  read strobe, reading entry w_index.
- r_done  out  1  read result valid, 1-cycle pulse.
- r_entry  out  111  {vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1}, registered.
- wired  in  IDXW  CP0 Wired.
- wired_we  in  1  Wired is being written this cycle.
- random  out  IDXW  current Random value.

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Reset: every entry's present bit clears (no match possible until written); other entry fields are don't-care.
- Reset values of outputs: all s_* outputs 0; p_done, r_done, p_found 0; p_index 0; r_entry 0; random = TLBNUM-1.
- Match, entry i: present[i] && vpn2[i]==key && (g[i] || asid[i]==asid).
- Port p, s_req=1 in cycle t: outputs update at edge t+1 and are valid in cycle t+1.
  - s_found = |match.
  - s_index = lowest matching index.
  - s_multi = popcount(match)>1.
  - Page fields come from the odd set when s_odd=1, else the even set.
  - No hit: s_found=0, s_multi=0, all other s_* fields 0.
- Port p, s_req=0: that port's outputs hold their last value.
- Write, tlbw=1: target = tlbwr ? random : w_index; the entry and its present bit are written at the edge.
- Write/search ordering: a search or probe in the same cycle as a write sees pre-write contents. A search in the next cycle sees the new entry.
- tlbp: p_found/p_index are registered exactly like a search port (lowest matching index); p_done pulses 1 cycle later. Probe miss: p_found=0, p_index=0.
- tlbr: r_entry = entry[w_index], registered; r_done pulses 1 cycle later. A non-present entry reads as all 0.
- tlbp/tlbr never stall and may overlap search traffic. With tlbp and tlbr asserted together, both complete.
- Random counter:
  - Decrements every cycle.
  - Random == wired: next value is TLBNUM-1.
  - wired_we: next value is TLBNUM-1, with priority over decrement.
  - Wired > TLBNUM-1 is illegal; behaviour is undefined.
  - tlbwr uses the pre-edge random value.
- rst mid-operation: pending results are dropped; no p_done/r_done is emitted in the cycle after reset.

Test Plan:
- Reset, then search vpn2=0x00000 on all ports -> s_found=0, s_multi=0; random=15 (TLBNUM=16).
- TLBWI index 3 {vpn2=0x12345, asid=0x05, g=0, pfn0=0xABCDE, v0=1, pfn1=0x11111}. Next cycle port0 search 0x12345/odd=0, asid=5 -> s_found=1, s_index=3, s_pfn=0xABCDE, s_v=1 at t+1. Same search with asid=6 -> miss.
- Write index 3 and search the same vpn2 in the same cycle -> miss (pre-write contents); repeat one cycle later -> hit.
- Write the same vpn2 with g=1 to indices 2 and 7 -> s_index=2, s_multi=1.
- Wired=4, no writes -> random sequence 15, 14 … 4, 15. Assert wired_we at random=9 -> next random=15. tlbwr at random=10 -> entry 10 written.
- tlbr on index 3 -> r_done pulse 1 cycle later with r_entry matching the fields written. tlbp on an absent vpn2 -> p_done=1, p_found=0.

Source files
------------

// File: rtl/tlb_mport.sv
// Fully associative TLB with NPORT registered search ports, probe/read ops and the CP0 Random counter.
// Each search port (and the probe) is one tlb_mport_lane looking at the shared entry array.

module tlb_mport_lane #(
   parameter int N    = 16,
   parameter int IDXW = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req,
   input  logic [18:0]          vpn2,
   input  logic                 odd,
   input  logic [7:0]           asid,
   input  logic [N-1:0]         e_pres,
   input  logic [N-1:0][18:0]   e_vpn2,
   input  logic [N-1:0][7:0]    e_asid,
   input  logic [N-1:0]         e_g,
   input  logic [N-1:0][24:0]   e_lo0,
   input  logic [N-1:0][24:0]   e_lo1,
   output logic                 found,
   output logic [IDXW-1:0]      index,
   output logic [19:0]          pfn,
   output logic [2:0]           c,
   output logic                 d,
   output logic                 v,
   output logic                 multi
);
   logic            hit, mul;
   logic [IDXW-1:0] idx;
   logic [24:0]     lo;

   // Scan downward so the last match seen is the lowest index; a second match flags multi.
   always_comb begin
      hit = 1'b0;
      mul = 1'b0;
      idx = '0;
      for (int i = N-1; i >= 0; i--) begin
         if (e_pres[i] && e_vpn2[i] == vpn2 && (e_g[i] || e_asid[i] == asid)) begin
            mul = mul | hit;
            hit = 1'b1;
            idx = IDXW'(i);
         end
      end
      lo = hit ? (odd ? e_lo1[idx] : e_lo0[idx]) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         found <= 1'b0;
         index <= '0;
         multi <= 1'b0;
         {pfn, c, d, v} <= '0;
      end else if (req) begin
         found <= hit;
         index <= idx;
         multi <= mul;
         {pfn, c, d, v} <= lo;
      end
   end
endmodule

module tlb_mport #(
   parameter int TLBNUM = 16,
   parameter int NPORT  = 2,
   localparam int IDXW  = $clog2(TLBNUM)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NPORT-1:0]      s_req,
   input  logic [NPORT*19-1:0]   s_vpn2,
   input  logic [NPORT-1:0]      s_odd,
   input  logic [7:0]            asid,
   output logic [NPORT-1:0]      s_found,
   output logic [NPORT*IDXW-1:0] s_index,
   output logic [NPORT*20-1:0]   s_pfn,
   output logic [NPORT*3-1:0]    s_c,
   output logic [NPORT-1:0]      s_d,
   output logic [NPORT-1:0]      s_v,
   output logic [NPORT-1:0]      s_multi,
   input  logic                  tlbw,
   input  logic                  tlbwr,
   input  logic [IDXW-1:0]       w_index,
   input  logic [18:0]           w_vpn2,
   input  logic [7:0]            w_asid,
   input  logic                  w_g,
   input  logic [19:0]           w_pfn0,
   input  logic [2:0]            w_c0,
   input  logic                  w_d0,
   input  logic                  w_v0,
   input  logic [19:0]           w_pfn1,
   input  logic [2:0]            w_c1,
   input  logic                  w_d1,
   input  logic                  w_v1,
   input  logic                  tlbp,
   output logic                  p_done,
   output logic                  p_found,
   output logic [IDXW-1:0]       p_index,
   input  logic                  tlbr,
   output logic                  r_done,
   output logic [110:0]          r_entry,
   input  logic [IDXW-1:0]       wired,
   input  logic                  wired_we,
   output logic [IDXW-1:0]       random
);
   logic [TLBNUM-1:0]        e_pres;
   logic [TLBNUM-1:0][18:0]  e_vpn2;
   logic [TLBNUM-1:0][7:0]   e_asid;
   logic [TLBNUM-1:0]        e_g;
   logic [TLBNUM-1:0][24:0]  e_lo0, e_lo1;
   logic [IDXW-1:0]          widx;
   logic [19:0]              p_unused_pfn;
   logic [2:0]               p_unused_c;
   logic                     p_unused_d, p_unused_v, p_unused_multi;

   assign widx = tlbwr ? random : w_index;

   always_ff @(posedge clk) begin
      if (rst)       e_pres <= '0;
      else if (tlbw) e_pres[widx] <= 1'b1;
   end

   // Entry payload needs no reset: a clear present bit masks it everywhere.
   always_ff @(posedge clk) begin
      if (tlbw) begin
         e_vpn2[widx] <= w_vpn2;
         e_asid[widx] <= w_asid;
         e_g[widx]    <= w_g;
         e_lo0[widx]  <= {w_pfn0, w_c0, w_d0, w_v0};
         e_lo1[widx]  <= {w_pfn1, w_c1, w_d1, w_v1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                            random <= IDXW'(TLBNUM-1);
      else if (wired_we || random == wired) random <= IDXW'(TLBNUM-1);
      else                                random <= random - 1'b1;
   end

   for (genvar p = 0; p < NPORT; p++) begin : g_port
      tlb_mport_lane #(.N(TLBNUM), .IDXW(IDXW)) u_lane (
         .clk(clk), .rst(rst), .req(s_req[p]),
         .vpn2(s_vpn2[p*19 +: 19]), .odd(s_odd[p]), .asid(asid),
         .e_pres(e_pres), .e_vpn2(e_vpn2), .e_asid(e_asid), .e_g(e_g),
         .e_lo0(e_lo0), .e_lo1(e_lo1),
         .found(s_found[p]), .index(s_index[p*IDXW +: IDXW]),
         .pfn(s_pfn[p*20 +: 20]), .c(s_c[p*3 +: 3]),
         .d(s_d[p]), .v(s_v[p]), .multi(s_multi[p])
      );
   end

   tlb_mport_lane #(.N(TLBNUM), .IDXW(IDXW)) u_probe (
      .clk(clk), .rst(rst), .req(tlbp),
      .vpn2(w_vpn2), .odd(1'b0), .asid(asid),
      .e_pres(e_pres), .e_vpn2(e_vpn2), .e_asid(e_asid), .e_g(e_g),
      .e_lo0(e_lo0), .e_lo1(e_lo1),
      .found(p_found), .index(p_index),
      .pfn(p_unused_pfn), .c(p_unused_c), .d(p_unused_d), .v(p_unused_v),
      .multi(p_unused_multi)
   );

   // The 78-bit entry image sits in the low bits; the upper bits of the port read as zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         p_done  <= 1'b0;
         r_done  <= 1'b0;
         r_entry <= '0;
      end else begin
         p_done <= tlbp;
         r_done <= tlbr;
         if (tlbr)
            r_entry <= e_pres[w_index] ?
                       {33'b0, e_vpn2[w_index], e_asid[w_index], e_g[w_index],
                        e_lo0[w_index], e_lo1[w_index]} : '0;
      end
   end
endmodule

// File: tb/tb_tlb_mport.sv
// Self-checking bench for tlb_mport: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a table-based reference model.

module tb_tlb_mport;
   localparam int N  = 16;
   localparam int NP = 2;
   localparam int IW = 4;

   logic clk = 1'b0;
   logic rst;
   logic [NP-1:0] s_req, s_odd;
   logic [NP*19-1:0] s_vpn2;
   logic [7:0] asid;
   logic [NP-1:0] s_found, s_d, s_v, s_multi;
   logic [NP*IW-1:0] s_index;
   logic [NP*20-1:0] s_pfn;
   logic [NP*3-1:0] s_c;
   logic tlbw, tlbwr, w_g, w_d0, w_v0, w_d1, w_v1, tlbp, tlbr, wired_we;
   logic [IW-1:0] w_index, wired, p_index, random;
   logic [18:0] w_vpn2;
   logic [7:0] w_asid;
   logic [19:0] w_pfn0, w_pfn1;
   logic [2:0] w_c0, w_c1;
   logic p_done, p_found, r_done;
   logic [110:0] r_entry;

   tlb_mport #(.TLBNUM(N), .NPORT(NP)) dut (
      .clk(clk), .rst(rst), .s_req(s_req), .s_vpn2(s_vpn2), .s_odd(s_odd), .asid(asid),
      .s_found(s_found), .s_index(s_index), .s_pfn(s_pfn), .s_c(s_c), .s_d(s_d), .s_v(s_v),
      .s_multi(s_multi), .tlbw(tlbw), .tlbwr(tlbwr), .w_index(w_index), .w_vpn2(w_vpn2),
      .w_asid(w_asid), .w_g(w_g), .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
      .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1), .tlbp(tlbp), .p_done(p_done),
      .p_found(p_found), .p_index(p_index), .tlbr(tlbr), .r_done(r_done), .r_entry(r_entry),
      .wired(wired), .wired_we(wired_we), .random(random)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [18:0] vpn2; logic [7:0] asid; logic g;
      logic [19:0] pfn0; logic [2:0] c0; logic d0, v0;
      logic [19:0] pfn1; logic [2:0] c1; logic d1, v1;
   } ent_t;

   ent_t m_ent[N];
   bit   m_pres[N];
   int   m_rnd;
   logic [NP-1:0] x_found, x_d, x_v, x_multi;
   logic [NP*IW-1:0] x_index;
   logic [NP*20-1:0] x_pfn;
   logic [NP*3-1:0] x_c;
   logic x_pdone, x_pfound, x_rdone;
   logic [IW-1:0] x_pindex;
   logic [110:0] x_rentry;

   function automatic void lookup(input logic [18:0] k, input logic [7:0] a,
                                  output int cnt, output int first);
      cnt = 0; first = 0;
      for (int i = 0; i < N; i++)
         if (m_pres[i] && m_ent[i].vpn2 == k && (m_ent[i].g || m_ent[i].asid == a)) begin
            if (cnt == 0) first = i;
            cnt++;
         end
   endfunction

   always @(posedge clk) begin : model
      int cnt, fst, tgt;
      ent_t e;
      if (rst) begin
         for (int i = 0; i < N; i++) m_pres[i] = 1'b0;
         x_found = '0; x_d = '0; x_v = '0; x_multi = '0; x_index = '0; x_pfn = '0; x_c = '0;
         x_pdone = 0; x_pfound = 0; x_rdone = 0; x_pindex = '0; x_rentry = '0;
         m_rnd = N-1;
      end else begin
         for (int p = 0; p < NP; p++)
            if (s_req[p]) begin
               lookup(s_vpn2[p*19 +: 19], asid, cnt, fst);
               e = m_ent[fst];
               x_found[p] = cnt > 0;
               x_multi[p] = cnt > 1;
               x_index[p*IW +: IW] = IW'(fst);
               if (cnt == 0) {x_pfn[p*20 +: 20], x_c[p*3 +: 3], x_d[p], x_v[p]} = '0;
               else if (s_odd[p]) {x_pfn[p*20 +: 20], x_c[p*3 +: 3], x_d[p], x_v[p]} = {e.pfn1, e.c1, e.d1, e.v1};
               else               {x_pfn[p*20 +: 20], x_c[p*3 +: 3], x_d[p], x_v[p]} = {e.pfn0, e.c0, e.d0, e.v0};
            end
         x_pdone = tlbp;
         if (tlbp) begin
            lookup(w_vpn2, asid, cnt, fst);
            x_pfound = cnt > 0;
            x_pindex = IW'(fst);
         end
         x_rdone = tlbr;
         if (tlbr) begin
            e = m_ent[w_index];
            x_rentry = m_pres[w_index] ? {33'b0, e.vpn2, e.asid, e.g, e.pfn0, e.c0, e.d0, e.v0,
                                          e.pfn1, e.c1, e.d1, e.v1} : '0;
         end
         if (tlbw) begin
            tgt = tlbwr ? m_rnd : int'(w_index);
            m_pres[tgt] = 1'b1;
            m_ent[tgt] = '{w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1};
         end
         if (wired_we || m_rnd == int'(wired)) m_rnd = N-1;
         else m_rnd = (m_rnd - 1) & (N-1);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("s_found", 128'(s_found), 128'(x_found));
         chk("s_index", 128'(s_index), 128'(x_index));
         chk("s_pfn",   128'(s_pfn),   128'(x_pfn));
         chk("s_c",     128'(s_c),     128'(x_c));
         chk("s_d",     128'(s_d),     128'(x_d));
         chk("s_v",     128'(s_v),     128'(x_v));
         chk("s_multi", 128'(s_multi), 128'(x_multi));
         chk("p_done",  128'(p_done),  128'(x_pdone));
         chk("p_found", 128'(p_found), 128'(x_pfound));
         chk("p_index", 128'(p_index), 128'(x_pindex));
         chk("r_done",  128'(r_done),  128'(x_rdone));
         chk("r_entry", 128'(r_entry), 128'(x_rentry));
         chk("random",  128'(random),  128'(m_rnd));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(negedge clk);
   endtask

   task automatic idle();
      s_req = '0; tlbw = 0; tlbwr = 0; tlbp = 0; tlbr = 0; wired_we = 0;
   endtask

   task automatic set_w(input logic [3:0] idx, input logic [18:0] vp, input logic [7:0] as,
                        input logic g, input logic [19:0] p0, input logic [19:0] p1);
      tlbw = 1; tlbwr = 0; w_index = idx; w_vpn2 = vp; w_asid = as; w_g = g;
      w_pfn0 = p0; w_c0 = 3'd3; w_d0 = 1; w_v0 = 1;
      w_pfn1 = p1; w_c1 = 3'd2; w_d1 = 0; w_v1 = 1;
   endtask

   task automatic search0(input logic [18:0] vp, input logic odd, input logic [7:0] as);
      s_req = 2'b01; s_vpn2[18:0] = vp; s_odd[0] = odd; asid = as;
   endtask

   logic [18:0] vpool[4] = '{19'h12345, 19'h2AAAA, 19'h33333, 19'h00000};

   initial begin
      rst = 1; s_vpn2 = '0; s_odd = '0; asid = '0; w_index = '0; w_vpn2 = '0; w_asid = '0;
      w_g = 0; w_pfn0 = '0; w_c0 = '0; w_d0 = 0; w_v0 = 0; w_pfn1 = '0; w_c1 = '0;
      w_d1 = 0; w_v1 = 0; wired = '0;
      idle();
      repeat (2) step();
      rst = 0;
      chk_en = 1;
      chk("reset random", 128'(random), 128'd15);
      chk("reset s_found", 128'(s_found), 128'd0);
      s_req = '1; s_vpn2 = '0; step();
      chk("empty found", 128'(s_found), 128'd0);
      chk("empty multi", 128'(s_multi), 128'd0);

      idle(); set_w(4'd3, 19'h12345, 8'h05, 0, 20'hABCDE, 20'h11111); step();
      idle(); search0(19'h12345, 0, 8'h05); step();
      chk("hit found", 128'(s_found[0]), 128'd1);
      chk("hit index", 128'(s_index[3:0]), 128'd3);
      chk("hit pfn", 128'(s_pfn[19:0]), 128'hABCDE);
      chk("hit v", 128'(s_v[0]), 128'd1);
      search0(19'h12345, 0, 8'h06); step();
      chk("asid miss", 128'(s_found[0]), 128'd0);

      set_w(4'd3, 19'h2AAAA, 8'h05, 0, 20'h13579, 20'h2468A);
      search0(19'h2AAAA, 1, 8'h05); step();
      chk("same-cycle miss", 128'(s_found[0]), 128'd0);
      tlbw = 0; step();
      chk("next-cycle hit", 128'(s_found[0]), 128'd1);
      chk("odd pfn", 128'(s_pfn[19:0]), 128'h2468A);

      idle(); set_w(4'd7, 19'h33333, 8'h99, 1, 20'h00007, 20'h00077); step();
      set_w(4'd2, 19'h33333, 8'h99, 1, 20'h00002, 20'h00022); step();
      idle(); search0(19'h33333, 0, 8'h05); step();
      chk("multi index", 128'(s_index[3:0]), 128'd2);
      chk("multi flag", 128'(s_multi[0]), 128'd1);
      chk("multi pfn", 128'(s_pfn[19:0]), 128'h00002);

      idle(); tlbr = 1; w_index = 4'd3; tlbp = 1; w_vpn2 = 19'h7FFFF; step();
      idle();
      chk("tlbr done", 128'(r_done), 128'd1);
      chk("tlbr entry", 128'(r_entry), {17'b0, 33'b0, 19'h2AAAA, 8'h05, 1'b0, 20'h13579, 3'd3,
                                         1'b1, 1'b1, 20'h2468A, 3'd2, 1'b0, 1'b1});
      chk("tlbp done", 128'(p_done), 128'd1);
      chk("tlbp miss", 128'(p_found), 128'd0);
      step();
      chk("tlbr pulse", 128'(r_done), 128'd0);

      wired = 4'd4; wired_we = 1; step();
      wired_we = 0;
      for (int k = 0; k < 13; k++) begin
         chk("wired seq", 128'(random), 128'((k < 12) ? 15 - k : 15));
         step();
      end
      for (int k = 0; k < 40 && random !== 4'd9; k++) step();
      chk("reach 9", 128'(random), 128'd9);
      wired_we = 1; step();
      wired_we = 0;
      chk("wired_we reload", 128'(random), 128'd15);
      for (int k = 0; k < 40 && random !== 4'd10; k++) step();
      chk("reach 10", 128'(random), 128'd10);
      set_w(4'd0, 19'h0ABCD, 8'h01, 0, 20'h0000A, 20'h000A0); tlbwr = 1; step();
      idle(); tlbr = 1; w_index = 4'd10; step();
      idle();
      chk("tlbwr done", 128'(r_done), 128'd1);
      chk("tlbwr vpn2", 128'(r_entry[77:59]), 128'h0ABCD);

      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 299) == 0);
         for (int p = 0; p < NP; p++) begin
            s_req[p] = $urandom_range(0, 1);
            s_odd[p] = $urandom_range(0, 1);
            s_vpn2[p*19 +: 19] = vpool[$urandom_range(0, 3)];
         end
         asid = $urandom_range(0, 1) ? 8'h05 : 8'h06;
         tlbw = ($urandom_range(0, 3) == 0); tlbwr = $urandom_range(0, 1);
         w_index = IW'($urandom_range(0, N-1));
         w_vpn2 = vpool[$urandom_range(0, 3)];
         w_asid = $urandom_range(0, 1) ? 8'h05 : 8'h06;
         w_g = ($urandom_range(0, 3) == 0);
         w_pfn0 = 20'($urandom); w_c0 = 3'($urandom); w_d0 = 1'($urandom); w_v0 = 1'($urandom);
         w_pfn1 = 20'($urandom); w_c1 = 3'($urandom); w_d1 = 1'($urandom); w_v1 = 1'($urandom);
         tlbp = ($urandom_range(0, 2) == 0); tlbr = ($urandom_range(0, 2) == 0);
         wired_we = ($urandom_range(0, 15) == 0);
         wired = IW'($urandom_range(0, N-1));
         step();
      end
      rst = 0; idle(); step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
